wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone B4 pipelined arbiter for the SATA controller bench and its register path.
- Lets two bus drivers (e.g. two scripted bus masters, or a scripted master plus a DMA) share one Wishbone slave port.
- Ownership is granted per bus cycle (CYC) and held until the owner drops CYC.
- Tracks outstanding requests per grant, saturates at a programmable depth, and aborts cleanly on bus error.

Parameters:
- AW, 5, word address width.
- DW, 32, data width; sel width is DW/8.
- LGOUT, 4, log2 of maximum outstanding requests; the counter is LGOUT+1 bits.
- OPT_ROUNDROBIN, 1, 1 = alternate on contention, 0 = fixed priority to A.
- OPT_ZERO_ON_IDLE, 0, 1 = drive o_we/o_addr/o_data/o_sel to 0 while no grant is held.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_a_cyc, i_a_stb, i_a_we  in  1  master A control
- i_a_addr  in  AW  master A address
- i_a_data  in  DW  master A write data
- i_a_sel  in  DW/8  master A byte select
- o_a_stall, o_a_ack, o_a_err  out  1  master A responses
- o_a_data  out  DW  master A read data
- i_b_* / o_b_*  (same widths)  master B, mirror of A
- o_cyc, o_stb, o_we  out  1  slave control
- o_addr  out  AW  slave address
- o_data  out  DW  slave write data
- o_sel  out  DW/8  slave byte select
- i_stall, i_ack, i_err  in  1  slave responses
- i_data  in  DW  slave read data

Behaviour:
- Reset is i_reset, synchronous, active-high; clock is i_clk.
- Reset values:
  - r_granted=0, r_owner=A, r_last=B (so A wins the first tie), r_count=0, r_abort=0.
  - Outputs in the reset cycle: o_cyc=0, o_stb=0, o_a/b_ack=0, o_a/b_err=0, o_a/b_stall=1.
- Grant (registered):
  - While !r_granted, or while the owner's cyc=0, arbitrate at each edge among requesters with cyc&&stb.
  - A single requester wins.
  - Both requesting: if OPT_ROUNDROBIN, the winner is the one != r_last; otherwise A.
  - On a grant, set r_granted=1, r_owner=winner, r_last=winner.
  - No requester: r_granted=0.
  - A request in cycle N becomes visible on o_stb in cycle N+1; the handover gap is one cycle.
- Owner view (combinational, from r_owner):
  - o_cyc = r_granted && owner_cyc && !r_abort.
  - o_stb = o_cyc && owner_stb && !full.
  - owner stall = i_stall || full || !r_granted.
  - owner ack = i_ack && o_cyc; owner err = i_err && o_cyc.
- Non-owner: stall=1, ack=0, err=0.
- o_a_data = o_b_data = i_data at all times.
- o_we/o_addr/o_data/o_sel: muxed from the owner; when !r_granted and OPT_ZERO_ON_IDLE, forced to 0.
- Outstanding counter r_count:
  - +1 on o_stb&&!i_stall; -1 on i_ack; both together: unchanged.
  - Cleared when o_cyc=0.
  - full = (r_count == 2^LGOUT); at full, o_stb is forced 0 and the owner is stalled.
  - An ack while r_count==0 is a protocol violation; the counter holds at 0, no underflow.
- Error:
  - i_err while o_cyc sets r_abort=1 and clears r_count at the next edge; from that cycle o_cyc=0.
  - The owner keeps the grant, receives no further acks, and sees stall=1.
  - r_abort clears, and the grant is released, when the owner's cyc falls.
- Owner drops cyc with r_count>0: o_cyc falls in the same cycle (abort), r_count clears, and late acks are not forwarded to anyone.
- Non-owner raises cyc mid-cycle: it stays stalled until the owner's cyc falls, then is granted at the next edge.
- Reset mid-transaction: all state returns to reset values at the edge and o_cyc=0 in the next cycle, regardless of the masters' inputs.

Test Plan:
- A alone writes 0xDEADBEEF to addr 3, slave acks after 2 cycles → o_stb high exactly 1 cycle starting the cycle after A's stb; o_a_ack 1 cycle; B sees stall=1, ack=0 throughout.
- A and B request in the same cycle, 3 times back to back with OPT_ROUNDROBIN=1 → grants go A, B, A; with OPT_ROUNDROBIN=0 → A, A, A. Each handover has exactly one idle cycle.
- LGOUT=2, A issues 6 pipelined reads, slave never stalls and holds acks → after 4 strobes o_stb=0 and o_a_stall=1; first ack → exactly one more strobe.
- B owns the bus with 2 outstanding, slave asserts i_err → o_b_err 1 cycle, o_cyc=0 next cycle, a later i_ack is not forwarded; when B drops cyc, a pending A is granted at the next edge.
- A drops cyc with 3 outstanding → o_cyc=0 in the same cycle, r_count=0 at the next edge, a stray i_ack produces no o_a_ack/o_b_ack.
- i_reset asserted mid-burst (4 outstanding) → next cycle o_cyc=0, o_stb=0, both stalls=1; after release, A's first request is granted ahead of B on a tie.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone B4 pipelined arbiter
// Grant is held per bus cycle; outstanding requests are counted and capped, bus errors abort the owner's cycle.
module wb_arbiter2 #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int LGOUT = 4,
    parameter bit OPT_ROUNDROBIN = 1'b1,
    parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_stall,
    input  logic            i_ack,
    input  logic            i_err,
    input  logic [DW-1:0]   i_data
);
    localparam logic [LGOUT:0] DEPTH = {1'b1, {LGOUT{1'b0}}};

    logic r_granted, r_owner, r_last, r_abort;
    logic [LGOUT:0] r_count, nxt_count;
    logic own_cyc, own_stb, own_stall, full, a_req, b_req, win, idle;

    assign own_cyc = r_owner ? i_b_cyc : i_a_cyc;
    assign own_stb = r_owner ? i_b_stb : i_a_stb;
    assign full = r_count == DEPTH;
    assign a_req = i_a_cyc && i_a_stb;
    assign b_req = i_b_cyc && i_b_stb;
    // On a tie round-robin hands the bus to whoever did not win last time
    assign win = (a_req && b_req) ? (OPT_ROUNDROBIN && !r_last) : b_req;

    assign o_cyc = r_granted && own_cyc && !r_abort;
    assign o_stb = o_cyc && own_stb && !full;
    assign own_stall = i_stall || full || !r_granted || r_abort;
    assign o_a_stall = r_owner ? 1'b1 : own_stall;
    assign o_b_stall = r_owner ? own_stall : 1'b1;
    assign o_a_ack = !r_owner && i_ack && o_cyc;
    assign o_b_ack = r_owner && i_ack && o_cyc;
    assign o_a_err = !r_owner && i_err && o_cyc;
    assign o_b_err = r_owner && i_err && o_cyc;
    assign o_a_data = i_data;
    assign o_b_data = i_data;

    assign idle = OPT_ZERO_ON_IDLE && !r_granted;
    assign o_we = !idle && (r_owner ? i_b_we : i_a_we);
    assign o_addr = idle ? '0 : (r_owner ? i_b_addr : i_a_addr);
    assign o_data = idle ? '0 : (r_owner ? i_b_data : i_a_data);
    assign o_sel = idle ? '0 : (r_owner ? i_b_sel : i_a_sel);

    // Acks with nothing outstanding are ignored so the counter never wraps
    assign nxt_count = (!o_cyc || i_err) ? '0
                     : r_count + {{LGOUT{1'b0}}, o_stb && !i_stall}
                               - {{LGOUT{1'b0}}, i_ack && r_count != '0};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_granted <= 1'b0;
            r_owner <= 1'b0;
            r_last <= 1'b1;
            r_count <= '0;
            r_abort <= 1'b0;
        end else begin
            r_count <= nxt_count;
            r_abort <= own_cyc && (r_abort || (o_cyc && i_err));
            if (!r_granted || !own_cyc) begin
                r_granted <= a_req || b_req;
                if (a_req || b_req) begin
                    r_owner <= win;
                    r_last <= win;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: vector table, directed corner sequences and random traffic for wb_arbiter2
// Two instances run side by side: defaults, and a shallow fixed-priority zero-on-idle variant.
module tb_wb_arbiter2;
    localparam int AW = 5, DW = 32, SW = DW / 8;
    localparam int MW = 1 + AW + DW + SW;

    logic i_clk = 1'b0, i_reset;
    logic a_cyc, a_stb, a_we, b_cyc, b_stb, b_we, stall, ack, err;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data, s_data;
    logic [SW-1:0] a_sel, b_sel;
    logic [1:0] o_cyc, o_stb, o_we, oa_stall, oa_ack, oa_err, ob_stall, ob_ack, ob_err;
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_data [2], oa_data [2], ob_data [2];
    logic [SW-1:0] o_sel [2];

    wb_arbiter2 #(.AW(AW), .DW(DW), .LGOUT(4), .OPT_ROUNDROBIN(1'b1), .OPT_ZERO_ON_IDLE(1'b0)) u0 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(oa_stall[0]), .o_a_ack(oa_ack[0]), .o_a_err(oa_err[0]), .o_a_data(oa_data[0]),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(ob_stall[0]), .o_b_ack(ob_ack[0]), .o_b_err(ob_err[0]), .o_b_data(ob_data[0]),
        .o_cyc(o_cyc[0]), .o_stb(o_stb[0]), .o_we(o_we[0]), .o_addr(o_addr[0]), .o_data(o_data[0]), .o_sel(o_sel[0]),
        .i_stall(stall), .i_ack(ack), .i_err(err), .i_data(s_data));

    wb_arbiter2 #(.AW(AW), .DW(DW), .LGOUT(2), .OPT_ROUNDROBIN(1'b0), .OPT_ZERO_ON_IDLE(1'b1)) u1 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(oa_stall[1]), .o_a_ack(oa_ack[1]), .o_a_err(oa_err[1]), .o_a_data(oa_data[1]),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(ob_stall[1]), .o_b_ack(ob_ack[1]), .o_b_err(ob_err[1]), .o_b_data(ob_data[1]),
        .o_cyc(o_cyc[1]), .o_stb(o_stb[1]), .o_we(o_we[1]), .o_addr(o_addr[1]), .o_data(o_data[1]), .o_sel(o_sel[1]),
        .i_stall(stall), .i_ack(ack), .i_err(err), .i_data(s_data));

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_bad = 0;
    int m_own [2], m_last [2], m_shown [2], m_cnt [2];
    bit m_abort [2];
    bit m_valid = 1'b0;
    logic [7:0] s_ctl [2];

    function automatic int depth(int k);
        return k == 1 ? 4 : 16;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference view: owner index (-1 = nobody), outstanding count, abort flag
    function automatic logic [7:0] exp_ctl(int k);
        int o = m_own[k];
        logic g = o >= 0;
        logic oc = g && (o == 1 ? b_cyc : a_cyc);
        logic ec = oc && !m_abort[k];
        logic full = m_cnt[k] == depth(k);
        logic es = ec && (o == 1 ? b_stb : a_stb) && !full;
        logic sa = !(g && o == 0) || stall || full || m_abort[k];
        logic sb = !(g && o == 1) || stall || full || m_abort[k];
        return {ec, es, sa, o == 0 && ec && ack, o == 0 && ec && err, sb, o == 1 && ec && ack, o == 1 && ec && err};
    endfunction

    function automatic logic [MW+2*DW-1:0] exp_dp(int k);
        logic idle = k == 1 && m_own[k] < 0;
        logic [MW-1:0] mux = m_shown[k] == 1 ? {b_we, b_addr, b_data, b_sel} : {a_we, a_addr, a_data, a_sel};
        return {mux & {MW{!idle}}, s_data, s_data};
    endfunction

    function automatic logic [7:0] got_ctl(int k);
        return {o_cyc[k], o_stb[k], oa_stall[k], oa_ack[k], oa_err[k], ob_stall[k], ob_ack[k], ob_err[k]};
    endfunction

    function automatic logic [MW+2*DW-1:0] got_dp(int k);
        return k == 0 ? {o_we[0], o_addr[0], o_data[0], o_sel[0], oa_data[0], ob_data[0]}
                      : {o_we[1], o_addr[1], o_data[1], o_sel[1], oa_data[1], ob_data[1]};
    endfunction

    task automatic update(int k);
        int o = m_own[k];
        int w = -1;
        logic g = o >= 0;
        logic oc = g && (o == 1 ? b_cyc : a_cyc);
        logic ec = oc && !m_abort[k];
        logic full = m_cnt[k] == depth(k);
        logic es = ec && (o == 1 ? b_stb : a_stb) && !full;
        logic ra = a_cyc && a_stb;
        logic rb = b_cyc && b_stb;
        if (i_reset) begin
            m_own[k] = -1; m_last[k] = 1; m_shown[k] = 0; m_cnt[k] = 0; m_abort[k] = 1'b0;
        end else begin
            if (!ec || err) m_cnt[k] = 0;
            else m_cnt[k] = m_cnt[k] + ((es && !stall) ? 1 : 0) - ((ack && m_cnt[k] > 0) ? 1 : 0);
            if (!oc) m_abort[k] = 1'b0;
            else if (ec && err) m_abort[k] = 1'b1;
            if (!g || !oc) begin
                if (ra && rb) w = (k == 0 && m_last[k] == 0) ? 1 : 0;
                else if (ra) w = 0;
                else if (rb) w = 1;
                m_own[k] = w;
                if (w >= 0) begin
                    m_last[k] = w;
                    m_shown[k] = w;
                end
            end
        end
    endtask

    task automatic tick();
        #3;
        for (int k = 0; k < 2; k++) begin
            s_ctl[k] = got_ctl(k);
            if (m_valid) begin
                chk($sformatf("ctl%0d", k), s_ctl[k], exp_ctl(k));
                chk($sformatf("dp%0d", k), got_dp(k), exp_dp(k));
            end
        end
        @(posedge i_clk);
        for (int k = 0; k < 2; k++) update(k);
        if (i_reset) m_valid = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [6:0] v);
        {a_cyc, a_stb, b_cyc, b_stb, stall, ack, err} = v;
        tick();
    endtask

    typedef struct packed {
        logic rst, ac, as, bc, bs, ak;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [20];

    initial begin
        int nstb;
        // exp bits: cyc stb a_stall a_ack a_err b_stall b_ack b_err (default instance)
        tbl = '{
            {6'b100000, 8'b00100100},
            {6'b011000, 8'b00100100}, {6'b011000, 8'b11000100}, {6'b010000, 8'b10000100},
            {6'b010001, 8'b10010100}, {6'b000000, 8'b00000100}, {6'b000000, 8'b00100100},
            {6'b100000, 8'b00100100},
            {6'b011110, 8'b00100100}, {6'b011110, 8'b11000100}, {6'b010101, 8'b10010100}, {6'b000000, 8'b00000100},
            {6'b011110, 8'b00100100}, {6'b011110, 8'b11100000}, {6'b010101, 8'b10100010}, {6'b000000, 8'b00100000},
            {6'b011110, 8'b00100100}, {6'b011110, 8'b11000100}, {6'b010101, 8'b10010100}, {6'b000000, 8'b00000100}
        };
        {a_cyc, a_stb, b_cyc, b_stb, stall, ack, err} = '0;
        a_we = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF; a_sel = 4'hF;
        b_we = 1'b0; b_addr = 5'd7; b_data = 32'h12345678; b_sel = 4'h3;
        s_data = 32'hCAFE0001;
        i_reset = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            {i_reset, a_cyc, a_stb, b_cyc, b_stb, ack} = {tbl[i].rst, tbl[i].ac, tbl[i].as, tbl[i].bc, tbl[i].bs, tbl[i].ak};
            stall = 1'b0; err = 1'b0;
            tick();
            chk($sformatf("vec%0d", i), s_ctl[0], tbl[i].exp);
        end

        // Shallow instance saturates at four outstanding, then one ack frees one strobe
        i_reset = 1'b1; drive(7'b0); i_reset = 1'b0;
        drive(7'b1100000);
        nstb = 0;
        for (int i = 0; i < 6; i++) begin drive(7'b1100000); nstb += int'(s_ctl[1][6]); end
        chk("full strobes", nstb, 4);
        chk("full stall", s_ctl[1][5], 1'b1);
        nstb = 0;
        drive(7'b1100010); nstb += int'(s_ctl[1][6]);
        drive(7'b1100000); nstb += int'(s_ctl[1][6]);
        drive(7'b1100000); nstb += int'(s_ctl[1][6]);
        chk("after ack strobes", nstb, 1);

        // Bus error on B with two outstanding, A waiting
        i_reset = 1'b1; drive(7'b0); i_reset = 1'b0;
        drive(7'b0011000); drive(7'b0011000); drive(7'b0011000);
        drive(7'b1110001);
        chk("err forward", s_ctl[0][0], 1'b1);
        drive(7'b1110010);
        chk("err abort", s_ctl[0], 8'b00100100);
        drive(7'b1100000);
        chk("err hold", s_ctl[0][5], 1'b1);
        drive(7'b1100000);
        chk("err handover", s_ctl[0], 8'b11000100);

        // A abandons its cycle with three outstanding; late acks go nowhere
        i_reset = 1'b1; drive(7'b0); i_reset = 1'b0;
        drive(7'b1100000); drive(7'b1100000); drive(7'b1100000); drive(7'b1100000);
        drive(7'b0000010);
        chk("drop cyc", {s_ctl[0][7], s_ctl[0][4], s_ctl[0][1]}, 3'b000);
        drive(7'b0000010);
        chk("drop stray ack", {s_ctl[0][4], s_ctl[0][1], s_ctl[1][4], s_ctl[1][1]}, 4'b0000);
        drive(7'b1100000);
        nstb = 0;
        for (int i = 0; i < 5; i++) begin drive(7'b1100000); nstb += int'(s_ctl[1][6]); end
        chk("drop count cleared", nstb, 4);

        // Reset in the middle of a saturated burst, both masters requesting
        i_reset = 1'b1; drive(7'b1111000); i_reset = 1'b0;
        drive(7'b1111000);
        chk("rst outputs0", s_ctl[0], 8'b00100100);
        chk("rst outputs1", s_ctl[1], 8'b00100100);
        drive(7'b1111000);
        chk("rst tie A", s_ctl[0], 8'b11000100);

        for (int i = 0; i < 3000; i++) begin
            i_reset = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 5) == 0) a_cyc = !a_cyc;
            if ($urandom_range(0, 5) == 0) b_cyc = !b_cyc;
            a_stb = a_cyc && $urandom_range(0, 2) != 0;
            b_stb = b_cyc && $urandom_range(0, 2) != 0;
            stall = $urandom_range(0, 3) == 0;
            ack = $urandom_range(0, 2) == 0;
            err = $urandom_range(0, 40) == 0;
            a_we = 1'($urandom); a_addr = AW'($urandom); a_data = $urandom; a_sel = SW'($urandom);
            b_we = 1'($urandom); b_addr = AW'($urandom); b_data = $urandom; b_sel = SW'($urandom);
            s_data = $urandom;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
